// File: rtl/cache_arb_pkg.sv
// Shared types, defaults and helpers for the cache request round-robin arbiter.
// The optional per-port packet counters are enabled with CACHE_ARB_STATS_EN.
package cache_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_REQ_DEF    = 4;
  localparam int ARB_DATA_WIDTH_DEF = 5;
  localparam int ARB_CNT_WIDTH_DEF  = 16;

  // Wide enough for any pointer up to the maximum of 8 requesters.
  localparam int ARB_PTR_W = 3;

  // Wrap increment by compare, so non-power-of-two port counts need no modulo.
  function automatic logic [ARB_PTR_W-1:0] rr_next(input logic [ARB_PTR_W-1:0] ptr,
                                                   input int n);
    if (ptr == ARB_PTR_W'(n - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// scanning upward with wrap; returns onehot grant, encoded id and an any flag.
module cache_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id,
  output logic            any
);

  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    grant = '0;
    id    = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N)) begin
        sum = sum - (ID_W+1)'(N);
      end
      idx = sum[ID_W-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/cache_req_rr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one cache request channel between
// NUM_REQ requesters, with a single registered output stage.
// Define CACHE_ARB_STATS_EN to add saturating per-port packet counters (o_grant_cnt).
module cache_req_rr_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ_DEF,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = ARB_CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [$clog2(NUM_REQ)-1:0]    o_src_id,
  output logic                          o_last,
  input  logic                          i_ready
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  o_grant_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE   = 1'(ARB_IDLE);
  localparam logic [0:0] ST_LOCKED = 1'(ARB_LOCKED);

  logic [0:0]            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       lock_id_q, lock_id_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [ID_W-1:0]       o_src_id_q, o_src_id_d;
  logic                  o_last_q, o_last_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [ID_W-1:0]       pick_id;
  logic                  pick_any;

  logic [NUM_REQ-1:0]    grant_oh;
  logic [ID_W-1:0]       sel_id;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  load_ok;
  logic                  accept;

  cache_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (i_req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  // While reset is held no beat may be accepted, so readiness is gated by rstn.
  always_comb begin
    load_ok = rstn & (~o_valid_q | i_ready);

    grant_oh = '0;
    sel_id   = pick_id;
    if (state_q == ST_LOCKED) begin
      grant_oh[lock_id_q] = 1'b1;
      sel_id              = lock_id_q;
    end else begin
      grant_oh = pick_grant;
    end

    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == sel_id) begin
        sel_valid = i_req_valid[k];
        sel_last  = i_req_last[k];
        sel_data  = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    accept      = load_ok & sel_valid & (|grant_oh);
    o_req_ready = grant_oh & {NUM_REQ{load_ok}};
  end

  always_comb begin
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_src_id_d = o_src_id_q;
    o_last_d   = o_last_q;
    if (accept) begin
      o_valid_d  = 1'b1;
      o_data_d   = sel_data;
      o_src_id_d = sel_id;
      o_last_d   = sel_last;
    end else if (i_ready) begin
      o_valid_d = 1'b0;
    end

    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      if (sel_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = ID_W'(rr_next(ARB_PTR_W'(sel_id), NUM_REQ));
      end else if (state_q == ST_IDLE) begin
        state_d   = ST_LOCKED;
        lock_id_d = sel_id;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_src_id_q <= '0;
      o_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_src_id_q <= o_src_id_d;
      o_last_q   <= o_last_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_data   = o_data_q;
  assign o_src_id = o_src_id_q;
  assign o_last   = o_last_q;

`ifdef CACHE_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];

  always_comb begin
    cnt_d = cnt_q;
    if (accept && sel_last) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (ID_W'(k) == sel_id && cnt_q[k] != '1) begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // NOTE: the counter array is reset element by element; it is a set of
  // flops with a defined power-on value, not a RAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign o_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_cache_req_rr_arbiter.sv
// Scoreboard bench for cache_req_rr_arbiter: directed packets per port, hand-ordered
// expected beats in a queue, a negedge monitor pops and compares every transfer.
module tb_cache_req_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 5;
`ifdef CACHE_ARB_STATS_EN
  localparam int CNT_W   = 4;
`else
  localparam int CNT_W   = 16;
`endif

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    i_req_last;
  logic [NUM_REQ*DW-1:0] i_req_data;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic                  o_valid;
  logic [DW-1:0]         o_data;
  logic [1:0]            o_src_id;
  logic                  o_last;
  logic                  i_ready;
`ifdef CACHE_ARB_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] o_grant_cnt;
`endif

  logic [5:0]         port_q [NUM_REQ][$];
  logic [7:0]         exp_q[$];
  logic [NUM_REQ-1:0] hold;
  int                 pass_cnt  = 0;
  int                 total_cnt = 0;

  cache_req_rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_src_id    (o_src_id),
    .o_last      (o_last),
    .i_ready     (i_ready)
`ifdef CACHE_ARB_STATS_EN
    ,
    .o_grant_cnt (o_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_beat(input int port, input logic [4:0] d, input logic l);
    port_q[port].push_back({d, l});
  endtask

  task automatic expect_beat(input logic [1:0] id, input logic [4:0] d, input logic l);
    exp_q.push_back({id, d, l});
  endtask

  task automatic drive();
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [5:0] b;
      if (port_q[k].size() > 0 && !hold[k]) begin
        b = port_q[k][0];
        i_req_valid[k]          = 1'b1;
        i_req_data[k*DW +: DW]  = b[5:1];
        i_req_last[k]           = b[0];
      end else begin
        i_req_valid[k]          = 1'b0;
        i_req_data[k*DW +: DW]  = '0;
        i_req_last[k]           = 1'b0;
      end
    end
  endtask

  // One clock: note handshakes at the negedge, retire them at the posedge, re-drive.
  task automatic step();
    logic [NUM_REQ-1:0] fire;
    @(negedge clk);
    fire = o_req_ready & i_req_valid;
    @(posedge clk);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (fire[k]) void'(port_q[k].pop_front());
    end
    #1;
    drive();
  endtask

  task automatic drain(input int limit, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < limit) begin
      step();
      cycles++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every beat transferred downstream must be the next expected one.
  always @(negedge clk) begin
    if (rstn && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {24'd0, o_src_id, o_data, o_last}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("beat_id",   32'(o_src_id), 32'(e[7:6]));
        check("beat_data", 32'(o_data),   32'(e[5:1]));
        check("beat_last", 32'(o_last),   32'(e[0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn    = 1'b0;
    i_ready = 1'b1;
    hold    = '0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_valid",  32'(o_valid),  32'd0);
    check("rst_o_data",   32'(o_data),   32'd0);
    check("rst_o_src_id", 32'(o_src_id), 32'd0);
    check("rst_o_last",   32'(o_last),   32'd0);

    // Test 1: all ports single-beat, rotation 0,1,2,3,0 with no bubbles.
    push_beat(0, 5'd1, 1'b1); push_beat(0, 5'd1, 1'b1);
    push_beat(1, 5'd2, 1'b1);
    push_beat(2, 5'd3, 1'b1);
    push_beat(3, 5'd4, 1'b1);
    drive();
    #1;
    check("rst_o_req_ready", 32'(o_req_ready), 32'd0);
    rstn = 1'b1;
    expect_beat(2'd0, 5'd1, 1'b1);
    expect_beat(2'd1, 5'd2, 1'b1);
    expect_beat(2'd2, 5'd3, 1'b1);
    expect_beat(2'd3, 5'd4, 1'b1);
    expect_beat(2'd0, 5'd1, 1'b1);
    drain(50, n);
    check("t1_cycles", 32'(n), 32'd6);

    // Test 2: port 1 holds the channel for a 3-beat packet, then 2, then 0.
    push_beat(0, 5'd8, 1'b1);
    push_beat(1, 5'd5, 1'b0); push_beat(1, 5'd6, 1'b0); push_beat(1, 5'd7, 1'b1);
    push_beat(2, 5'd9, 1'b1);
    drive();
    expect_beat(2'd1, 5'd5, 1'b0);
    expect_beat(2'd1, 5'd6, 1'b0);
    expect_beat(2'd1, 5'd7, 1'b1);
    expect_beat(2'd2, 5'd9, 1'b1);
    expect_beat(2'd0, 5'd8, 1'b1);
    drain(50, n);
    check("t2_cycles", 32'(n), 32'd6);

    // Test 3: port 2 locked, drops valid for two cycles mid-packet.
    push_beat(2, 5'd10, 1'b0); push_beat(2, 5'd11, 1'b0);
    push_beat(2, 5'd12, 1'b0); push_beat(2, 5'd13, 1'b1);
    push_beat(3, 5'd15, 1'b1);
    push_beat(0, 5'd16, 1'b1);
    drive();
    expect_beat(2'd2, 5'd10, 1'b0);
    expect_beat(2'd2, 5'd11, 1'b0);
    expect_beat(2'd2, 5'd12, 1'b0);
    expect_beat(2'd2, 5'd13, 1'b1);
    expect_beat(2'd3, 5'd15, 1'b1);
    expect_beat(2'd0, 5'd16, 1'b1);
    n = 0;
    while (port_q[2].size() > 2 && n < 20) begin
      step();
      n++;
    end
    check("t3_lock_progress", 32'(port_q[2].size()), 32'd2);
    hold[2] = 1'b1;
    drive();
    for (int c = 0; c < 2; c++) begin
      step();
      check("t3_bubble_valid", 32'(o_valid), 32'd0);
      check("t3_bubble_no_grant", 32'(o_req_ready & 4'b1011), 32'd0);
    end
    hold[2] = 1'b0;
    drive();
    drain(50, n);

    // Test 4: downstream stall for 5 cycles with 5'h1A held on the output.
    push_beat(3, 5'h1A, 1'b1);
    push_beat(0, 5'd3, 1'b1);
    drive();
    step();
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_hold_valid",  32'(o_valid),     32'd1);
      check("t4_hold_data",   32'(o_data),      32'h1A);
      check("t4_hold_src",    32'(o_src_id),    32'd3);
      check("t4_ready_low",   32'(o_req_ready), 32'd0);
    end
    i_ready = 1'b1;
    expect_beat(2'd3, 5'h1A, 1'b1);
    expect_beat(2'd0, 5'd3,  1'b1);
    drain(50, n);

    // Test 5: reset while port 3 is mid-packet; port 0 wins afterwards.
    push_beat(3, 5'd20, 1'b0); push_beat(3, 5'd21, 1'b0); push_beat(3, 5'd22, 1'b1);
    drive();
    expect_beat(2'd3, 5'd20, 1'b0);
    step();
    step();
    rstn = 1'b0;
    #1;
    check("t5_rst_valid", 32'(o_valid),  32'd0);
    check("t5_rst_src",   32'(o_src_id), 32'd0);
    check("t5_rst_data",  32'(o_data),   32'd0);
    check("t5_rst_last",  32'(o_last),   32'd0);
    port_q[3].delete();
    for (int k = 0; k < NUM_REQ; k++) push_beat(k, 5'(24 + k), 1'b1);
    drive();
    #1;
    check("t5_rst_ready", 32'(o_req_ready), 32'd0);
    step();
    step();
    rstn = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) expect_beat(2'(k), 5'(24 + k), 1'b1);
    drain(50, n);
    check("t5_cycles", 32'(n), 32'd5);

`ifdef CACHE_ARB_STATS_EN
    // Test 6: 20 packets on port 0 saturate a 4-bit counter at 4'hF.
    rstn = 1'b0;
    #1;
    check("t6_rst_cnt", 32'(o_grant_cnt), 32'd0);
    step();
    rstn = 1'b1;
    for (int p = 0; p < 20; p++) begin
      push_beat(0, 5'(p), 1'b1);
      expect_beat(2'd0, 5'(p), 1'b1);
    end
    drive();
    drain(100, n);
    check("t6_cnt0", 32'(o_grant_cnt[0 +: CNT_W]), 32'hF);
    check("t6_cnt_others", 32'(o_grant_cnt[NUM_REQ*CNT_W-1:CNT_W]), 32'd0);
`endif

    repeat (2) step();
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
